// File: rtl/img_frame_sched.sv
// rtl/img_frame_sched.sv - frame-level run/stop sequencer for the image source
// Optional FRAME_GEOM_CHK_EN adds per-frame pixel/line geometry checking.
module img_frame_sched #(
  parameter int ACTIVE_IW = 640,
  parameter int ACTIVE_IH = 480,
  parameter int ARM_TMO   = 1000000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [CNT_W-1:0] frame_num,
  input  logic             vs_in,
  input  logic             de_in,
  output logic             src_en,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             arm_tmo,
  output logic             geom_err
);
  localparam int TMO_W = $clog2(ARM_TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t             state_q, state_d;
  logic               vs_r_q, vs_r_d, vs_p_q, vs_p_d;
  logic [CNT_W-1:0]   num_q, num_d, cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               arm_tmo_q, arm_tmo_d, geom_err_q, geom_err_d;
  logic               stop_pend_q, stop_pend_d, src_en_q, src_en_d;
  logic               frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic               vs_rise, vs_fall, geom_bad;
  logic [CNT_W:0]     cnt_inc;

  assign vs_rise = vs_r_q & ~vs_p_q;
  assign vs_fall = ~vs_r_q & vs_p_q;
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

`ifdef FRAME_GEOM_CHK_EN
  logic        de_r_q, de_r_d, de_p_q, de_p_d;
  logic [19:0] pix_q, pix_d;
  logic [11:0] lines_q, lines_d;

  // Counters restart on every vs rise so only the current frame body is measured.
  always_comb begin
    de_r_d  = de_in;
    de_p_d  = de_r_q;
    pix_d   = pix_q;
    lines_d = lines_q;
    if (vs_rise) begin
      pix_d   = '0;
      lines_d = '0;
    end else begin
      if (de_r_q && pix_q != 20'hFFFFF) pix_d = pix_q + 20'd1;
      if (de_p_q && !de_r_q && lines_q != 12'hFFF) lines_d = lines_q + 12'd1;
    end
  end

  assign geom_bad = (pix_q != 20'(ACTIVE_IW * ACTIVE_IH)) || (lines_q != 12'(ACTIVE_IH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_r_q  <= 1'b0;
      de_p_q  <= 1'b0;
      pix_q   <= '0;
      lines_q <= '0;
    end else begin
      de_r_q  <= de_r_d;
      de_p_q  <= de_p_d;
      pix_q   <= pix_d;
      lines_q <= lines_d;
    end
  end
`else
  logic unused_de;
  assign unused_de = de_in;
  assign geom_bad  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    vs_r_d        = vs_in;
    vs_p_d        = vs_r_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    arm_tmo_d     = arm_tmo_q;
    geom_err_d    = geom_err_q;
    stop_pend_d   = stop_pend_q;
    src_en_d      = src_en_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_stop) begin
          state_d     = S_ARM;
          num_d       = frame_num;
          cnt_d       = '0;
          tmo_cnt_d   = '0;
          arm_tmo_d   = 1'b0;
          geom_err_d  = 1'b0;
          stop_pend_d = 1'b0;
          src_en_d    = 1'b1;
        end
      end
      S_ARM: begin
        if (vs_rise) begin
          state_d       = S_RUN;
          frame_start_d = 1'b1;
        end else if (cmd_stop) begin
          state_d  = S_IDLE;
          src_en_d = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(ARM_TMO - 1)) begin
          state_d   = S_IDLE;
          src_en_d  = 1'b0;
          arm_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (vs_rise) frame_start_d = 1'b1;
        if (vs_fall) begin
          frame_done_d = 1'b1;
          cnt_d        = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
          if (geom_bad) geom_err_d = 1'b1;
          // A stop arriving on the frame-end cycle itself still ends the run here.
          if (stop_pend_q || cmd_stop || (num_q != '0 && cnt_inc == {1'b0, num_q})) begin
            state_d     = S_IDLE;
            src_en_d    = 1'b0;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        src_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vs_r_q        <= 1'b0;
      vs_p_q        <= 1'b0;
      num_q         <= '0;
      cnt_q         <= '0;
      tmo_cnt_q     <= '0;
      arm_tmo_q     <= 1'b0;
      geom_err_q    <= 1'b0;
      stop_pend_q   <= 1'b0;
      src_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_r_q        <= vs_r_d;
      vs_p_q        <= vs_p_d;
      num_q         <= num_d;
      cnt_q         <= cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      arm_tmo_q     <= arm_tmo_d;
      geom_err_q    <= geom_err_d;
      stop_pend_q   <= stop_pend_d;
      src_en_q      <= src_en_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign src_en      = src_en_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = cnt_q;
  assign arm_tmo     = arm_tmo_q;
  assign geom_err    = geom_err_q;
endmodule
